dpram_arb: RTL and testbench
============================

DPRAM_ARB -- requirements
Module: dpram_arb

Interface
REQ-001 SHALL have no parameters; geometry fixed at 128 words x 32 bits, 4 byte lanes.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clr_start  in  1  one-cycle pulse requesting a RAM zero-fill sweep.
REQ-005 clr_busy  out  1  high while sweep in progress.
REQ-006 r0_req  in  1  requester 0 access request; held with payload until granted.
REQ-007 r0_we  in  4  byte-lane write enables; 4'h0 = read.
REQ-008 r0_addr  in  7  word address.
REQ-009 r0_wdata  in  32  write data.
REQ-010 r0_gnt  out  1  access accepted this cycle (combinational from req and state).
REQ-011 r0_rvalid  out  1  read data valid pulse.
REQ-012 r0_rdata  out  32  read data, meaningful only when r0_rvalid=1.
REQ-013 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: identical set for requester 1.
REQ-014 ram_we  out  4  byte write enables to the RAM port.
REQ-015 ram_addr  out  7  address to the RAM port.
REQ-016 ram_din  out  32  write data to the RAM port.
REQ-017 ram_dout  in  32  RAM read data, registered in RAM, one cycle after address.

Function
REQ-018 States: CLR (zero-fill sweep), RUN (arbitration); grants SHALL issue only in RUN.
REQ-019 RUN, one req high: that requester granted same cycle.
REQ-020 RUN, both req high: grant the requester not granted most recently; pointer updates on every grant.
REQ-021 Granted requester's we/addr/wdata SHALL drive ram_we/ram_addr/ram_din combinationally in the grant cycle.
REQ-022 No grant: ram_we=4'h0, ram_addr=7'h0, ram_din=32'h0.
REQ-023 At most one gnt high per cycle.
REQ-024 Read grant (we=4'h0) in cycle N: that requester's rvalid=1 in cycle N+1, rdata=ram_dout; rvalid registered.
REQ-025 Write grant: no rvalid; read of the written address granted next cycle returns new data.
REQ-026 Back-to-back grants to one requester allowed every cycle when the other is idle; throughput 1 access/cycle.
REQ-027 CLR: 7-bit counter 0..127, one word per cycle, ram_we=4'hF, ram_din=0, ram_addr=counter; after word 127 go to RUN next cycle; sweep = 128 cycles.
REQ-028 clr_start in RUN: state CLR from next cycle; a grant issued in the same cycle as clr_start completes, including its rvalid.
REQ-029 clr_start during CLR: ignored, counter not restarted.
REQ-030 req held during CLR: gnt=0; arbitration resumes the first RUN cycle.

Reset
REQ-031 rst: state RUN (CLR when DPRAM_ARB_CLR_EN defined, counter 0), pointer = requester 1 so requester 0 wins first tie.
REQ-032 rst: r0_rvalid=r1_rvalid=0, clr_busy=0 (1 with CLR_EN); reads in flight discarded.

Configuration
REQ-033 DPRAM_ARB_CLR_EN defined: CLR state, counter, clr_busy and clr_start functional; reset enters CLR.
REQ-034 DPRAM_ARB_CLR_EN undefined: no CLR logic; clr_busy tied 0, clr_start ignored, reset enters RUN.

Verification
REQ-035 CLR_EN, release rst -> clr_busy high 128 cycles, ram_we=4'hF addr 0..127 din 0, then r0 read addr 5 -> rvalid next cycle, rdata 0.
REQ-036 Both req every cycle, reads addr 1 and 2 -> grants alternate r0,r1,r0,...; r0 first after reset.
REQ-037 r0 write addr 10 we=4'h3 data 32'hAABBCCDD over 32'h11223344 -> r1 read addr 10 next cycle returns 32'h1122CCDD.
REQ-038 r1 read grant same cycle as clr_start -> r1_rvalid next cycle; r0_req during sweep gets gnt=0 for 128 cycles, granted first RUN cycle.
REQ-039 rst asserted cycle after read grant -> no rvalid; outputs at reset values next cycle.
REQ-040 CLR_EN undefined: clr_start pulse -> clr_busy stays 0, r0 granted same cycle.

Source files
------------

// File: rtl/dpram_arb_if.sv
// Requester, RAM-port and zero-fill control signals of dpram_arb.
// slave = arbiter side, master = requesters + RAM side.
interface dpram_arb_if;
    logic        clr_start;
    logic        clr_busy;

    logic        r0_req;
    logic [3:0]  r0_we;
    logic [6:0]  r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_gnt;
    logic        r0_rvalid;
    logic [31:0] r0_rdata;

    logic        r1_req;
    logic [3:0]  r1_we;
    logic [6:0]  r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_gnt;
    logic        r1_rvalid;
    logic [31:0] r1_rdata;

    logic [3:0]  ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport slave (
        input  clr_start,
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  ram_dout,
        output clr_busy,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output clr_start,
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output ram_dout,
        input  clr_busy,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/dpram_arb.sv
// Two-requester round-robin arbiter in front of a 128x32 byte-lane RAM port.
// Define DPRAM_ARB_CLR_EN to enable the zero-fill sweep (CLR state, clr_start/clr_busy).
module dpram_arb (
    input  logic       clk,
    input  logic       rst,
    dpram_arb_if.slave bus
);
    logic        last_r1;   // 1: requester 1 holds the most recent grant
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic        clr_active;
    logic [6:0]  clr_cnt;
    logic [3:0]  mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_din;

`ifdef DPRAM_ARB_CLR_EN
    typedef enum logic {ST_RUN, ST_CLR} state_t;
    state_t      state, state_nxt;
    logic [6:0]  clr_cnt_nxt;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_RUN: begin
                if (bus.clr_start) begin
                    state_nxt   = ST_CLR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLR: begin
                clr_cnt_nxt = clr_cnt + 7'd1;
                if (clr_cnt == 7'd127) begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    assign clr_active = (state == ST_CLR);
`else
    logic unused_clr_start;
    assign unused_clr_start = bus.clr_start;
    assign clr_active       = 1'b0;
    assign clr_cnt          = '0;
`endif

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (clr_active) begin
            mem_we   = '1;
            mem_addr = clr_cnt;
        end else if (bus.r0_req && (!bus.r1_req || last_r1)) begin
            gnt0     = 1'b1;
            mem_we   = bus.r0_we;
            mem_addr = bus.r0_addr;
            mem_din  = bus.r0_wdata;
        end else if (bus.r1_req) begin
            gnt1     = 1'b1;
            mem_we   = bus.r1_we;
            mem_addr = bus.r1_addr;
            mem_din  = bus.r1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_r1 <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            if (gnt0) begin
                last_r1 <= 1'b0;
            end else if (gnt1) begin
                last_r1 <= 1'b1;
            end
            rvalid0 <= gnt0 && (bus.r0_we == 4'h0);
            rvalid1 <= gnt1 && (bus.r1_we == 4'h0);
        end
    end

    // RAM output is already registered, so read data is passed straight through
    assign bus.r0_rdata  = bus.ram_dout;
    assign bus.r1_rdata  = bus.ram_dout;
    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_rvalid = rvalid0;
    assign bus.r1_rvalid = rvalid1;
    assign bus.ram_we    = mem_we;
    assign bus.ram_addr  = mem_addr;
    assign bus.ram_din   = mem_din;
    assign bus.clr_busy  = clr_active;
endmodule

// File: tb/tb_dpram_arb.sv
// Bench for dpram_arb: directed scenarios plus random traffic against a
// cycle-level reference model; follows DPRAM_ARB_CLR_EN like the design.
module tb_dpram_arb;
`ifdef DPRAM_ARB_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dpram_arb_if bus ();
    dpram_arb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // RAM behind the port: byte-lane writes, read data registered
    logic [31:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    // Reference model: who won last, sweep words remaining, shadow memory, pending read
    int          last_win  = 1;
    int          clr_left  = 0;
    int          pend      = -1;
    logic [31:0] pend_data = '0;
    logic [31:0] shadow [128];

    int          exp_win;
    logic        exp_busy;
    logic [3:0]  exp_we;
    logic [6:0]  exp_addr;
    logic [31:0] exp_din;
    logic        exp_rv0, exp_rv1;

    task automatic model_eval();
        exp_busy = (clr_left > 0);
        exp_win  = -1;
        exp_we   = 4'h0;
        exp_addr = 7'h0;
        exp_din  = 32'h0;
        if (clr_left > 0) begin
            exp_we   = 4'hF;
            exp_addr = 7'(128 - clr_left);
        end else begin
            if (bus.r0_req && bus.r1_req) exp_win = 1 - last_win;
            else if (bus.r0_req)          exp_win = 0;
            else if (bus.r1_req)          exp_win = 1;
            if (exp_win == 0) begin
                exp_we = bus.r0_we; exp_addr = bus.r0_addr; exp_din = bus.r0_wdata;
            end else if (exp_win == 1) begin
                exp_we = bus.r1_we; exp_addr = bus.r1_addr; exp_din = bus.r1_wdata;
            end
        end
        exp_rv0 = (pend == 0);
        exp_rv1 = (pend == 1);
    endtask

    task automatic model_commit();
        int nxt_pend = -1;
        if (clr_left > 0) begin
            shadow[128 - clr_left] = 32'h0;
            clr_left--;
        end else begin
            if (exp_win >= 0) begin
                last_win = exp_win;
                if (exp_we == 4'h0) begin
                    nxt_pend  = exp_win;
                    pend_data = shadow[exp_addr];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (exp_we[b]) shadow[exp_addr][8*b +: 8] = exp_din[8*b +: 8];
                end
            end
            if (CLR_EN && bus.clr_start) clr_left = 128;
        end
        pend = nxt_pend;
        if (rst) begin
            last_win = 1;
            clr_left = CLR_EN ? 128 : 0;
            pend     = -1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_start = 1'b0;
        bus.r0_req = 1'b0; bus.r0_we = 4'h0; bus.r0_addr = 7'h0; bus.r0_wdata = 32'h0;
        bus.r1_req = 1'b0; bus.r1_we = 4'h0; bus.r1_addr = 7'h0; bus.r1_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        while (clr_left > 0) begin settle(); tick(); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        settle();
        checks++; if (bus.r0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rv0 got=%b exp=0", bus.r0_rvalid); end
        checks++; if (bus.r1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rv1 got=%b exp=0", bus.r1_rvalid); end
        checks++; if (bus.clr_busy !== CLR_EN) begin errors++; $display("FAIL rst_busy got=%b exp=%b", bus.clr_busy, CLR_EN); end
        checks++; if (bus.ram_we !== (CLR_EN ? 4'hF : 4'h0)) begin errors++; $display("FAIL rst_we got=%h", bus.ram_we); end
        checks++; if (bus.ram_addr !== 7'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.ram_addr); end
        checks++; if (bus.r0_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%b exp=0", bus.r0_gnt); end
        tick();
    endtask

`ifdef DPRAM_ARB_CLR_EN
    task automatic test_clear_sweep();
        bus.r0_req = 1'b1; bus.r0_we = 4'h0; bus.r0_addr = 7'd5;
        for (int i = 1; i < 128; i++) begin
            settle();
            checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL sweep_busy i=%0d got=%b exp=1", i, bus.clr_busy); end
            checks++; if (bus.ram_we !== 4'hF) begin errors++; $display("FAIL sweep_we i=%0d got=%h exp=f", i, bus.ram_we); end
            checks++; if (bus.ram_addr !== 7'(i)) begin errors++; $display("FAIL sweep_addr got=%0d exp=%0d", bus.ram_addr, i); end
            checks++; if (bus.ram_din !== 32'h0) begin errors++; $display("FAIL sweep_din i=%0d got=%h exp=0", i, bus.ram_din); end
            checks++; if (bus.r0_gnt !== 1'b0) begin errors++; $display("FAIL sweep_gnt0 i=%0d got=%b exp=0", i, bus.r0_gnt); end
            tick();
        end
        settle();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL sweep_end_busy got=%b exp=0", bus.clr_busy); end
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL sweep_end_gnt0 got=%b exp=1", bus.r0_gnt); end
        tick();
        bus.r0_req = 1'b0;
        settle();
        checks++; if (bus.r0_rvalid !== 1'b1) begin errors++; $display("FAIL sweep_rv0 got=%b exp=1", bus.r0_rvalid); end
        checks++; if (bus.r0_rdata !== 32'h0) begin errors++; $display("FAIL sweep_rdata got=%h exp=0", bus.r0_rdata); end
        tick();
    endtask

    task automatic test_clr_start();
        idle_inputs();
        bus.r1_req = 1'b1; bus.r1_we = 4'h0; bus.r1_addr = 7'd10;
        bus.clr_start = 1'b1;
        settle();
        checks++; if (bus.r1_gnt !== 1'b1) begin errors++; $display("FAIL cs_gnt1 got=%b exp=1", bus.r1_gnt); end
        tick();
        bus.r1_req = 1'b0;
        bus.r0_req = 1'b1; bus.r0_we = 4'h0; bus.r0_addr = 7'd10;
        for (int i = 0; i < 128; i++) begin
            bus.clr_start = (i == 60);
            settle();
            if (i == 0) begin
                checks++; if (bus.r1_rvalid !== 1'b1) begin errors++; $display("FAIL cs_rv1 got=%b exp=1", bus.r1_rvalid); end
                checks++; if (bus.r1_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL cs_rdata1 got=%h exp=1122ccdd", bus.r1_rdata); end
            end
            checks++; if (bus.r0_gnt !== 1'b0) begin errors++; $display("FAIL cs_gnt0 i=%0d got=%b exp=0", i, bus.r0_gnt); end
            checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL cs_busy i=%0d got=%b exp=1", i, bus.clr_busy); end
            checks++; if (bus.ram_addr !== 7'(i)) begin errors++; $display("FAIL cs_addr got=%0d exp=%0d", bus.ram_addr, i); end
            tick();
        end
        bus.clr_start = 1'b0;
        settle();
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL cs_first_run_gnt0 got=%b exp=1", bus.r0_gnt); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL cs_end_busy got=%b exp=0", bus.clr_busy); end
        tick();
        bus.r0_req = 1'b0;
        settle();
        checks++; if (bus.r0_rvalid !== 1'b1) begin errors++; $display("FAIL cs_rv0 got=%b exp=1", bus.r0_rvalid); end
        checks++; if (bus.r0_rdata !== 32'h0) begin errors++; $display("FAIL cs_rdata0 got=%h exp=0", bus.r0_rdata); end
        tick();
    endtask
`else
    task automatic test_clr_ignored();
        idle_inputs();
        bus.clr_start = 1'b1;
        bus.r0_req = 1'b1; bus.r0_we = 4'h0; bus.r0_addr = 7'd10;
        settle();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL ci_busy got=%b exp=0", bus.clr_busy); end
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL ci_gnt0 got=%b exp=1", bus.r0_gnt); end
        tick();
        bus.clr_start = 1'b0; bus.r0_req = 1'b0;
        settle();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL ci_busy2 got=%b exp=0", bus.clr_busy); end
        checks++; if (bus.r0_rvalid !== 1'b1) begin errors++; $display("FAIL ci_rv0 got=%b exp=1", bus.r0_rvalid); end
        checks++; if (bus.r0_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL ci_rdata got=%h exp=1122ccdd", bus.r0_rdata); end
        tick();
    endtask
`endif

    task automatic test_alternate();
        do_reset();
        bus.r0_req = 1'b1; bus.r0_we = 4'h0; bus.r0_addr = 7'd1;
        bus.r1_req = 1'b1; bus.r1_we = 4'h0; bus.r1_addr = 7'd2;
        for (int i = 0; i < 8; i++) begin
            settle();
            checks++; if (bus.r0_gnt !== ((i % 2) == 0)) begin errors++; $display("FAIL alt_gnt0 i=%0d got=%b", i, bus.r0_gnt); end
            checks++; if (bus.r1_gnt !== ((i % 2) == 1)) begin errors++; $display("FAIL alt_gnt1 i=%0d got=%b", i, bus.r1_gnt); end
            checks++; if (bus.ram_addr !== (((i % 2) == 0) ? 7'd1 : 7'd2)) begin errors++; $display("FAIL alt_addr i=%0d got=%0d", i, bus.ram_addr); end
            if (i > 0) begin
                checks++; if (bus.r0_rvalid !== ((i % 2) == 1)) begin errors++; $display("FAIL alt_rv0 i=%0d got=%b", i, bus.r0_rvalid); end
                checks++; if (bus.ram_dout !== pend_data) begin errors++; $display("FAIL alt_rdata i=%0d got=%h exp=%h", i, bus.ram_dout, pend_data); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        idle_inputs();
        bus.r0_req = 1'b1; bus.r0_we = 4'hF; bus.r0_addr = 7'd10; bus.r0_wdata = 32'h11223344;
        settle();
        checks++; if (bus.r0_gnt !== 1'b1) begin errors++; $display("FAIL bw_gnt_a got=%b exp=1", bus.r0_gnt); end
        tick();
        bus.r0_we = 4'h3; bus.r0_wdata = 32'hAABBCCDD;
        settle();
        checks++; if (bus.ram_we !== 4'h3) begin errors++; $display("FAIL bw_we got=%h exp=3", bus.ram_we); end
        tick();
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b1; bus.r1_we = 4'h0; bus.r1_addr = 7'd10;
        settle();
        checks++; if (bus.r0_rvalid !== 1'b0) begin errors++; $display("FAIL bw_no_rv0 got=%b exp=0", bus.r0_rvalid); end
        checks++; if (bus.r1_gnt !== 1'b1) begin errors++; $display("FAIL bw_gnt1 got=%b exp=1", bus.r1_gnt); end
        tick();
        bus.r1_req = 1'b0;
        settle();
        checks++; if (bus.r1_rvalid !== 1'b1) begin errors++; $display("FAIL bw_rv1 got=%b exp=1", bus.r1_rvalid); end
        checks++; if (bus.r1_rdata !== 32'h1122CCDD) begin errors++; $display("FAIL bw_rdata got=%h exp=1122ccdd", bus.r1_rdata); end
        tick();
    endtask

    task automatic test_reset_discard();
        idle_inputs();
        bus.r0_req = 1'b1; bus.r0_we = 4'h0; bus.r0_addr = 7'd3;
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        settle();
        checks++; if (bus.r0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rv0 got=%b exp=0", bus.r0_rvalid); end
        checks++; if (bus.r1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rv1 got=%b exp=0", bus.r1_rvalid); end
        checks++; if (bus.clr_busy !== CLR_EN) begin errors++; $display("FAIL rd_busy got=%b exp=%b", bus.clr_busy, CLR_EN); end
        checks++; if (bus.r0_gnt !== !CLR_EN) begin errors++; $display("FAIL rd_gnt0 got=%b exp=%b", bus.r0_gnt, !CLR_EN); end
        tick();
        bus.r0_req = 1'b0;
        while (clr_left > 0) begin settle(); tick(); end
    endtask

    task automatic test_random();
        logic        rq  [2];
        logic [3:0]  rwe [2];
        logic [6:0]  rad [2];
        logic [31:0] rwd [2];
        do_reset();
        for (int k = 0; k < 2; k++) rq[k] = 1'b0;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rq[k]) begin
                    rq[k]  = ($urandom_range(0, 3) != 0);
                    rwe[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    rad[k] = 7'($urandom_range(0, 15));
                    rwd[k] = $urandom;
                end
            end
            bus.r0_req = rq[0]; bus.r0_we = rwe[0]; bus.r0_addr = rad[0]; bus.r0_wdata = rwd[0];
            bus.r1_req = rq[1]; bus.r1_we = rwe[1]; bus.r1_addr = rad[1]; bus.r1_wdata = rwd[1];
            bus.clr_start = ($urandom_range(0, 149) == 0);
            settle();
            checks++; if (bus.r0_gnt !== (exp_win == 0)) begin errors++; $display("FAIL rnd_gnt0 n=%0d got=%b exp=%b", n, bus.r0_gnt, exp_win == 0); end
            checks++; if (bus.r1_gnt !== (exp_win == 1)) begin errors++; $display("FAIL rnd_gnt1 n=%0d got=%b exp=%b", n, bus.r1_gnt, exp_win == 1); end
            checks++; if (bus.ram_we !== exp_we) begin errors++; $display("FAIL rnd_we n=%0d got=%h exp=%h", n, bus.ram_we, exp_we); end
            checks++; if (bus.ram_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.ram_addr, exp_addr); end
            checks++; if (bus.ram_din !== exp_din) begin errors++; $display("FAIL rnd_din n=%0d got=%h exp=%h", n, bus.ram_din, exp_din); end
            checks++; if (bus.r0_rvalid !== exp_rv0) begin errors++; $display("FAIL rnd_rv0 n=%0d got=%b exp=%b", n, bus.r0_rvalid, exp_rv0); end
            checks++; if (bus.r1_rvalid !== exp_rv1) begin errors++; $display("FAIL rnd_rv1 n=%0d got=%b exp=%b", n, bus.r1_rvalid, exp_rv1); end
            checks++; if (bus.clr_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, bus.clr_busy, exp_busy); end
            if (exp_rv0) begin
                checks++; if (bus.r0_rdata !== pend_data) begin errors++; $display("FAIL rnd_rdata0 n=%0d got=%h exp=%h", n, bus.r0_rdata, pend_data); end
            end
            if (exp_rv1) begin
                checks++; if (bus.r1_rdata !== pend_data) begin errors++; $display("FAIL rnd_rdata1 n=%0d got=%h exp=%h", n, bus.r1_rdata, pend_data); end
            end
            tick();
            for (int k = 0; k < 2; k++) if (exp_win == k) rq[k] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
        idle_inputs();
        test_reset();
`ifdef DPRAM_ARB_CLR_EN
        test_clear_sweep();
`endif
        test_alternate();
        test_byte_write();
`ifdef DPRAM_ARB_CLR_EN
        test_clr_start();
`else
        test_clr_ignored();
`endif
        test_reset_discard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
